// File: rtl/ddr_init_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ddr_init_pkg : shared types and constants for the DDR3 init sequencer     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package ddr_init_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_RST_HOLD  = 4'd1,
    ST_CKE_HOLD  = 4'd2,
    ST_XPR_WAIT  = 4'd3,
    ST_MRS_ISSUE = 4'd4,
    ST_MRS_WAIT  = 4'd5,
    ST_ZQ_ISSUE  = 4'd6,
    ST_ZQ_WAIT   = 4'd7,
    ST_DONE      = 4'd8
  } init_state_e;

  typedef struct packed {
    logic cs_n;
    logic ras_n;
    logic cas_n;
    logic we_n;
  } dfi_cmd_t;

  localparam dfi_cmd_t c_cmd_des  = 4'b1111;
  localparam dfi_cmd_t c_cmd_nop  = 4'b0111;
  localparam dfi_cmd_t c_cmd_mrs  = 4'b0000;
  localparam dfi_cmd_t c_cmd_zqcl = 4'b0110;

  // Issue order by index: element [0] is MR2, then MR3, MR1, MR0.
  localparam logic [3:0][1:0] c_mr_order    = {2'd0, 2'd1, 2'd3, 2'd2};
  localparam logic [1:0]      c_mr_last_idx = 2'd3;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : ddr_init_pkg
`default_nettype wire

// File: rtl/init_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | init_timer : loadable down-counter that parks at zero                    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module init_timer #(
  parameter int WIDTH = 8
) (
  input  logic             core_clk,
  input  logic             core_arstn,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule : init_timer
`default_nettype wire

// File: rtl/dfi_init_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dfi_init_sequencer : DDR3 power-up / MRS / ZQCL bring-up on DFI           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module dfi_init_sequencer
  import ddr_init_pkg::*;
#(
  parameter int          T_RESET  = 80000,
  parameter int          T_CKE    = 200000,
  parameter int          T_XPR    = 108,
  parameter int          T_MRD    = 4,
  parameter int          T_MOD    = 12,
  parameter int          T_ZQINIT = 512,
  parameter logic [15:0] MR0_VAL  = 16'h0000,
  parameter logic [15:0] MR1_VAL  = 16'h0000,
  parameter logic [15:0] MR2_VAL  = 16'h0000,
  parameter logic [15:0] MR3_VAL  = 16'h0000,
  parameter int          ADDR_W   = 16,
  parameter int          BANK_W   = 3
) (
  input  logic              core_clk,
  input  logic              core_arstn,
  input  logic              init_start,
  output logic              init_busy,
  output logic              init_done,
  output logic              dfi_reset_n,
  output logic              dfi_cke,
  output logic              dfi_odt,
  output logic              dfi_cs_n,
  output logic              dfi_ras_n,
  output logic              dfi_cas_n,
  output logic              dfi_we_n,
  output logic [ADDR_W-1:0] dfi_address,
  output logic [BANK_W-1:0] dfi_bank
);

  localparam int T_MAX = max_of(max_of(max_of(T_RESET, T_CKE), max_of(T_XPR, T_MRD)),
                                max_of(T_MOD, T_ZQINIT));
  localparam int TW    = $clog2(T_MAX + 1);

  // Timer holds remaining cycles minus one; the wait states already lose one
  // cycle to the preceding single-cycle issue state, hence the -2 loads.
  localparam logic [TW-1:0] c_ld_reset = TW'(T_RESET - 1);
  localparam logic [TW-1:0] c_ld_cke   = TW'(T_CKE - 1);
  localparam logic [TW-1:0] c_ld_xpr   = TW'(T_XPR - 1);
  localparam logic [TW-1:0] c_ld_mrd   = TW'(T_MRD - 2);
  localparam logic [TW-1:0] c_ld_mod   = TW'(T_MOD - 2);
  localparam logic [TW-1:0] c_ld_zq    = TW'(T_ZQINIT - 2);

  localparam logic [ADDR_W-1:0] c_zq_addr = ADDR_W'(16'h0400);

  init_state_e       state_q, state_d;
  logic [1:0]        mr_idx_q, mr_idx_d;
  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic              tmr_zero;

  dfi_cmd_t          cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic              reset_n_q, reset_n_d;
  logic              cke_q, cke_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        mr_num_d;

  init_timer #(
    .WIDTH (TW)
  ) u_timer (
    .core_clk   (core_clk),
    .core_arstn (core_arstn),
    .load_i     (tmr_load),
    .value_i    (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    mr_idx_d = mr_idx_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (init_start) begin
          state_d  = ST_RST_HOLD;
          mr_idx_d = 2'd0;
          tmr_load = 1'b1;
          tmr_val  = c_ld_reset;
        end
      end
      ST_RST_HOLD: begin
        if (tmr_zero) begin
          state_d  = ST_CKE_HOLD;
          tmr_load = 1'b1;
          tmr_val  = c_ld_cke;
        end
      end
      ST_CKE_HOLD: begin
        if (tmr_zero) begin
          state_d  = ST_XPR_WAIT;
          tmr_load = 1'b1;
          tmr_val  = c_ld_xpr;
        end
      end
      ST_XPR_WAIT: begin
        if (tmr_zero) begin
          state_d = ST_MRS_ISSUE;
        end
      end
      ST_MRS_ISSUE: begin
        state_d  = ST_MRS_WAIT;
        tmr_load = 1'b1;
        tmr_val  = (mr_idx_q == c_mr_last_idx) ? c_ld_mod : c_ld_mrd;
      end
      ST_MRS_WAIT: begin
        if (tmr_zero) begin
          if (mr_idx_q == c_mr_last_idx) begin
            state_d = ST_ZQ_ISSUE;
          end else begin
            state_d  = ST_MRS_ISSUE;
            mr_idx_d = mr_idx_q + 2'd1;
          end
        end
      end
      ST_ZQ_ISSUE: begin
        state_d  = ST_ZQ_WAIT;
        tmr_load = 1'b1;
        tmr_val  = c_ld_zq;
      end
      ST_ZQ_WAIT: begin
        if (tmr_zero) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the entry edge.
  assign mr_num_d = c_mr_order[mr_idx_d];

  always_comb begin
    cmd_d     = c_cmd_nop;
    addr_d    = '0;
    bank_d    = '0;
    reset_n_d = 1'b1;
    cke_d     = 1'b1;
    busy_d    = 1'b1;
    done_d    = 1'b0;
    case (state_d)
      ST_IDLE: begin
        cmd_d     = c_cmd_des;
        reset_n_d = 1'b0;
        cke_d     = 1'b0;
        busy_d    = 1'b0;
      end
      ST_RST_HOLD: begin
        cmd_d     = c_cmd_des;
        reset_n_d = 1'b0;
        cke_d     = 1'b0;
      end
      ST_CKE_HOLD: begin
        cmd_d = c_cmd_des;
        cke_d = 1'b0;
      end
      ST_MRS_ISSUE: begin
        cmd_d  = c_cmd_mrs;
        bank_d = BANK_W'(mr_num_d);
        case (mr_num_d)
          2'd0: addr_d = ADDR_W'(MR0_VAL);
          2'd1: addr_d = ADDR_W'(MR1_VAL);
          2'd2: addr_d = ADDR_W'(MR2_VAL);
          2'd3: addr_d = ADDR_W'(MR3_VAL);
        endcase
      end
      ST_ZQ_ISSUE: begin
        cmd_d  = c_cmd_zqcl;
        addr_d = c_zq_addr;
      end
      ST_DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: begin
        cmd_d = c_cmd_nop;
      end
    endcase
  end

  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      state_q   <= ST_IDLE;
      mr_idx_q  <= 2'd0;
      cmd_q     <= c_cmd_des;
      addr_q    <= '0;
      bank_q    <= '0;
      reset_n_q <= 1'b0;
      cke_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mr_idx_q  <= mr_idx_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      bank_q    <= bank_d;
      reset_n_q <= reset_n_d;
      cke_q     <= cke_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign dfi_cs_n    = cmd_q.cs_n;
  assign dfi_ras_n   = cmd_q.ras_n;
  assign dfi_cas_n   = cmd_q.cas_n;
  assign dfi_we_n    = cmd_q.we_n;
  assign dfi_address = addr_q;
  assign dfi_bank    = bank_q;
  assign dfi_reset_n = reset_n_q;
  assign dfi_cke     = cke_q;
  assign dfi_odt     = 1'b0;
  assign init_busy   = busy_q;
  assign init_done   = done_q;

endmodule : dfi_init_sequencer
`default_nettype wire

// File: tb/tb_dfi_init_sequencer.sv
`default_nettype none
// Scoreboard bench for dfi_init_sequencer: stimulus queues the expected
// timeline of events, a negedge monitor pops and compares as they appear.
module tb_dfi_init_sequencer;

  localparam int          ADDR_W = 16;
  localparam int          BANK_W = 3;
  localparam logic [15:0] MR0    = 16'h1D70;
  localparam logic [15:0] MR1    = 16'h0044;
  localparam logic [15:0] MR2    = 16'h0018;
  localparam logic [15:0] MR3    = 16'h0008;

  localparam logic [2:0] K_RSTN = 3'd0;
  localparam logic [2:0] K_CKE  = 3'd1;
  localparam logic [2:0] K_MRS  = 3'd2;
  localparam logic [2:0] K_ZQ   = 3'd3;
  localparam logic [2:0] K_DONE = 3'd4;
  localparam logic [2:0] K_BAD  = 3'd7;

  // {reset_n, cke, odt, cs/ras/cas/we, address, bank, busy, done}
  localparam logic [27:0] RESET_VEC = {1'b0, 1'b0, 1'b0, 4'b1111, 16'h0000, 3'd0, 1'b0, 1'b0};

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] edge_no;
    logic [2:0]  bank;
    logic [15:0] addr;
  } ev_t;

  logic              clk;
  logic              rst_n;
  logic              init_start;
  logic              init_busy, init_done;
  logic              dfi_reset_n, dfi_cke, dfi_odt;
  logic              dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n;
  logic [ADDR_W-1:0] dfi_address;
  logic [BANK_W-1:0] dfi_bank;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   mrs_seen = 0;
  int   zq_seen  = 0;
  ev_t  exp_q[$];
  logic prev_rstn = 1'b0;
  logic prev_cke  = 1'b0;
  logic prev_done = 1'b0;

  dfi_init_sequencer #(
    .T_RESET  (4),
    .T_CKE    (6),
    .T_XPR    (3),
    .T_MRD    (2),
    .T_MOD    (3),
    .T_ZQINIT (5),
    .MR0_VAL  (MR0),
    .MR1_VAL  (MR1),
    .MR2_VAL  (MR2),
    .MR3_VAL  (MR3),
    .ADDR_W   (ADDR_W),
    .BANK_W   (BANK_W)
  ) dut (
    .core_clk    (clk),
    .core_arstn  (rst_n),
    .init_start  (init_start),
    .init_busy   (init_busy),
    .init_done   (init_done),
    .dfi_reset_n (dfi_reset_n),
    .dfi_cke     (dfi_cke),
    .dfi_odt     (dfi_odt),
    .dfi_cs_n    (dfi_cs_n),
    .dfi_ras_n   (dfi_ras_n),
    .dfi_cas_n   (dfi_cas_n),
    .dfi_we_n    (dfi_we_n),
    .dfi_address (dfi_address),
    .dfi_bank    (dfi_bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [27:0] outs();
    return {dfi_reset_n, dfi_cke, dfi_odt, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n,
            dfi_address, dfi_bank, init_busy, init_done};
  endfunction

  function automatic ev_t mk(input logic [2:0] k, input int e, input logic [2:0] b,
                             input logic [15:0] a);
    ev_t ev;
    ev.kind    = k;
    ev.edge_no = e[31:0];
    ev.bank    = b;
    ev.addr    = a;
    return ev;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic observe(input ev_t got);
    ev_t want;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: kind=%0d edge=%0d bank=%0d addr=0x%h, nothing expected",
               got.kind, got.edge_no, got.bank, got.addr);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        fails++;
        $display("FAIL event: got kind=%0d edge=%0d bank=%0d addr=0x%h, expected kind=%0d edge=%0d bank=%0d addr=0x%h",
                 got.kind, got.edge_no, got.bank, got.addr,
                 want.kind, want.edge_no, want.bank, want.addr);
      end
    end
  endtask

  // Hand-computed timeline for the small parameter set, relative to the
  // edge after which init_start is first driven high.
  task automatic push_sequence(input int s, input int n);
    ev_t seq [8];
    seq[0] = mk(K_RSTN, s + 5,  3'd0, 16'h0000);
    seq[1] = mk(K_CKE,  s + 11, 3'd0, 16'h0000);
    seq[2] = mk(K_MRS,  s + 14, 3'd2, MR2);
    seq[3] = mk(K_MRS,  s + 16, 3'd3, MR3);
    seq[4] = mk(K_MRS,  s + 18, 3'd1, MR1);
    seq[5] = mk(K_MRS,  s + 20, 3'd0, MR0);
    seq[6] = mk(K_ZQ,   s + 23, 3'd0, 16'h0400);
    seq[7] = mk(K_DONE, s + 28, 3'd0, 16'h0000);
    for (int i = 0; i < n; i++) exp_q.push_back(seq[i]);
  endtask

  always @(negedge clk) begin
    logic [3:0] cmd;
    logic [2:0] k;
    if (!rst_n) begin
      prev_rstn <= 1'b0;
      prev_cke  <= 1'b0;
      prev_done <= 1'b0;
    end else begin
      cmd = {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n};
      check("odt_low", {31'd0, dfi_odt}, 32'd0);
      if (!dfi_cke) check("cs_n_while_cke_low", {31'd0, dfi_cs_n}, 32'd1);
      if (prev_done) check("done_sticky", {31'd0, init_done}, 32'd1);
      if (dfi_cs_n || cmd == 4'b0111)
        check("idle_addr_bank", {13'd0, dfi_bank, dfi_address}, 32'd0);
      if (dfi_reset_n && !prev_rstn) observe(mk(K_RSTN, cyc, 3'd0, 16'h0000));
      if (dfi_cke && !prev_cke) observe(mk(K_CKE, cyc, 3'd0, 16'h0000));
      if (!dfi_cs_n && cmd != 4'b0111) begin
        if (cmd == 4'b0000) k = K_MRS;
        else if (cmd == 4'b0110) k = K_ZQ;
        else k = K_BAD;
        if (k == K_MRS) mrs_seen <= mrs_seen + 1;
        if (k == K_ZQ) zq_seen <= zq_seen + 1;
        observe(mk(k, cyc, dfi_bank, dfi_address));
      end
      if (init_done && !prev_done) observe(mk(K_DONE, cyc, 3'd0, 16'h0000));
      prev_rstn <= dfi_reset_n;
      prev_cke  <= dfi_cke;
      prev_done <= init_done;
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_empty(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int m0, z0;
    rst_n      = 1'b0;
    init_start = 1'b0;
    @(negedge clk);
    check("reset_outputs", {4'd0, outs()}, {4'd0, RESET_VEC});
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_no_start", {4'd0, outs()}, {4'd0, RESET_VEC});
    end

    // Full sequence, single-cycle start pulse.
    @(negedge clk);
    s = cyc;
    init_start = 1'b1;
    check("busy_before_start", {31'd0, init_busy}, 32'd0);
    push_sequence(s, 8);
    @(negedge clk);
    init_start = 1'b0;
    check("busy_after_start", {31'd0, init_busy}, 32'd1);
    wait_empty(60, "seqA_drain");
    check("seqA_done", {31'd0, init_done}, 32'd1);
    check("seqA_busy", {31'd0, init_busy}, 32'd0);
    check("seqA_reset_n_cke", {30'd0, dfi_reset_n, dfi_cke}, 32'd3);

    // Asynchronous reset while waiting after MR3.
    apply_reset();
    @(negedge clk);
    s = cyc;
    init_start = 1'b1;
    push_sequence(s, 4);
    @(negedge clk);
    init_start = 1'b0;
    while (cyc < s + 17) @(negedge clk);
    check("queue_before_arst", exp_q.size(), 32'd0);
    rst_n = 1'b0;
    #1;
    check("arst_outputs", {4'd0, outs()}, {4'd0, RESET_VEC});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("no_restart_without_start", {4'd0, outs()}, {4'd0, RESET_VEC});
    s = cyc;
    init_start = 1'b1;
    push_sequence(s, 8);
    @(negedge clk);
    init_start = 1'b0;
    check("restart_busy", {31'd0, init_busy}, 32'd1);
    wait_empty(60, "restart_drain");
    check("restart_done", {31'd0, init_done}, 32'd1);

    // init_start held high through DONE: exactly one sequence.
    apply_reset();
    @(negedge clk);
    s = cyc;
    m0 = mrs_seen;
    z0 = zq_seen;
    init_start = 1'b1;
    push_sequence(s, 8);
    wait_empty(60, "held_drain");
    repeat (20) @(negedge clk);
    check("held_mrs_count", mrs_seen - m0, 32'd4);
    check("held_zq_count", zq_seen - z0, 32'd1);
    check("held_done", {31'd0, init_done}, 32'd1);
    init_start = 1'b0;
    repeat (2) @(negedge clk);

    check("queue_final", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_dfi_init_sequencer
`default_nettype wire
